// File: rtl/cp0.sv
// CP0: system control coprocessor holding SR, Cause, EPC and PRId.
// Raises Req combinationally for enabled interrupts or synchronous exceptions,
// and records exception state on the edge the request is taken.
module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0Add,
   input  logic [31:0] CP0In,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] CP0Out,
   output logic [31:0] EPCOut,
   output logic        Req
);

   localparam logic [4:0]  ADDR_SR    = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE = 5'd13;
   localparam logic [4:0]  ADDR_EPC   = 5'd14;
   localparam logic [4:0]  ADDR_PRID  = 5'd15;
   localparam logic [31:0] PRID_VAL   = 32'h2024_0001;

   // SR fields
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   // Cause fields
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   // EPC is word aligned, so only bits [31:2] are stored
   logic [29:0] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_entry;
   logic [31:0] sr_rd;
   logic [31:0] cause_rd;
   logic [31:0] epc_rd;

   // Request generation; EXL masks everything while an exception is being handled
   always_comb begin
      int_req   = (|(HWInt & im_q)) && ie_q && !exl_q;
      exc_req   = (ExcCodeIn != 5'd0) && !exl_q;
      Req       = int_req || exc_req;
      // Modulo-2^32 subtraction backs up to the branch owning the delay slot
      epc_entry = BDIn ? (VPC - 32'd4) : VPC;
   end

   // Next-state: exception entry beats mtc0 writes and eret on the same edge
   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      ip_d  = HWInt;
      exc_d = exc_q;
      epc_d = epc_q;
      if (Req) begin
         exl_d = 1'b1;
         exc_d = int_req ? 5'd0 : ExcCodeIn;
         bd_d  = BDIn;
         epc_d = epc_entry[31:2];
      end else begin
         if (EXLClr) begin
            exl_d = 1'b0;
         end
         if (en && (CP0Add == ADDR_SR)) begin
            im_d  = CP0In[15:10];
            ie_d  = CP0In[0];
            exl_d = EXLClr ? 1'b0 : CP0In[1];
         end
         if (en && (CP0Add == ADDR_EPC)) begin
            epc_d = CP0In[31:2];
         end
      end
   end

   // Register update with synchronous reset clearing SR, Cause and EPC
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   // Combinational mfc0 read of pre-edge state; unimplemented addresses read zero
   always_comb begin
      sr_rd    = {16'd0, im_q, 8'd0, exl_q, ie_q};
      cause_rd = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
      epc_rd   = {epc_q, 2'b00};
      EPCOut   = epc_rd;
      case (CP0Add)
         ADDR_SR:    CP0Out = sr_rd;
         ADDR_CAUSE: CP0Out = cause_rd;
         ADDR_EPC:   CP0Out = epc_rd;
         ADDR_PRID:  CP0Out = PRID_VAL;
         default:    CP0Out = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0.sv
// Testbench for cp0: directed vectors, expectations queued by the stimulus
// process and compared by an independent monitor on the falling edge.
module tb_cp0;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] CP0Out;
   logic [31:0] EPCOut;
   logic        Req;

   localparam int SEL_REQ = 0;
   localparam int SEL_OUT = 1;
   localparam int SEL_EPC = 2;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   cp0 dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .CP0Add    (CP0Add),
      .CP0In     (CP0In),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .CP0Out    (CP0Out),
      .EPCOut    (EPCOut),
      .Req       (Req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are combinational, so every queued expectation is due at the next falling edge
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
               SEL_REQ: act = {31'd0, Req};
               SEL_OUT: act = CP0Out;
               default: act = EPCOut;
            endcase
            checks++;
            if (act !== e.val) begin
               failures++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic read_exp(input string name, input logic [4:0] addr, input logic [31:0] val);
      CP0Add = addr;
      expect_val(name, SEL_OUT, val);
      step();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = '0; VPC = '0;
      BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      CP0Add = 5'd12;
      expect_val("rst_req", SEL_REQ, 32'd0);
      expect_val("rst_epcout", SEL_EPC, 32'd0);
      expect_val("rst_sr", SEL_OUT, 32'd0);
      step();
      read_exp("rst_cause", 5'd13, 32'd0);
      read_exp("rst_epc", 5'd14, 32'd0);
      read_exp("prid", 5'd15, 32'h2024_0001);

      // Exception entry and return
      ExcCodeIn = 5'd4; VPC = 32'h0000_3008; BDIn = 1'b0;
      expect_val("exc_req_same_cycle", SEL_REQ, 32'd1);
      step();
      expect_val("exc_req_masked", SEL_REQ, 32'd0);
      expect_val("exc_epc", SEL_EPC, 32'h0000_3008);
      read_exp("exc_cause", 5'd13, 32'h0000_0010);
      read_exp("exc_sr_exl", 5'd12, 32'h0000_0002);
      ExcCodeIn = 5'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
      read_exp("eret_sr", 5'd12, 32'h0000_0000);

      // Delay-slot exception
      VPC = 32'h0000_300C; BDIn = 1'b1; ExcCodeIn = 5'd10;
      expect_val("bd_req", SEL_REQ, 32'd1);
      step();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      expect_val("bd_epc", SEL_EPC, 32'h0000_3008);
      read_exp("bd_cause", 5'd13, 32'h8000_0028);
      EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;

      // Interrupt enabled
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
      expect_val("int_idle_req", SEL_REQ, 32'd0);
      step();
      en = 1'b0; HWInt = 6'b000001; VPC = 32'h0000_4000;
      expect_val("int_req", SEL_REQ, 32'd1);
      step();
      expect_val("int_masked_in_exl", SEL_REQ, 32'd0);
      read_exp("int_cause", 5'd13, 32'h0000_0400);
      read_exp("int_epc", 5'd14, 32'h0000_4000);
      HWInt = 6'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;

      // Interrupt with IE=0: no request but IP tracks
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0400;
      step();
      en = 1'b0; HWInt = 6'b000001;
      expect_val("ie0_req", SEL_REQ, 32'd0);
      step();
      read_exp("ie0_cause_ip", 5'd13, 32'h0000_0400);
      read_exp("ie0_sr", 5'd12, 32'h0000_0400);

      // Interrupt beats exception; same-edge mtc0 EPC discarded
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
      step();
      ExcCodeIn = 5'd12; VPC = 32'h0000_5004; BDIn = 1'b0;
      CP0Add = 5'd14; CP0In = 32'h1234_5678;
      expect_val("prio_req", SEL_REQ, 32'd1);
      step();
      en = 1'b0; ExcCodeIn = 5'd0;
      expect_val("prio_epc", SEL_EPC, 32'h0000_5004);
      read_exp("prio_cause", 5'd13, 32'h0000_0400);
      HWInt = 6'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;

      // Simultaneous Req and EXLClr: Req wins
      ExcCodeIn = 5'd3; EXLClr = 1'b1; VPC = 32'h0000_6000;
      expect_val("req_eret_req", SEL_REQ, 32'd1);
      step();
      ExcCodeIn = 5'd0; EXLClr = 1'b0;
      read_exp("req_eret_sr", 5'd12, 32'h0000_0403);

      // mtc0 SR with EXLClr: EXL cleared, other fields from CP0In
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0403; EXLClr = 1'b1;
      step();
      en = 1'b0; EXLClr = 1'b0;
      read_exp("sr_wr_eret", 5'd12, 32'h0000_0401);

      // Write masking and alignment
      en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_3003;
      step();
      en = 1'b0;
      expect_val("epc_align", SEL_EPC, 32'h0000_3000);
      step();
      en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
      step();
      en = 1'b0;
      read_exp("cause_wr_ignored", 5'd13, 32'h0000_000C);
      read_exp("addr3_zero", 5'd3, 32'h0000_0000);
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'hFFFF_FFFF;
      step();
      en = 1'b0;
      read_exp("sr_mask", 5'd12, 32'h0000_FC03);
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0000;
      step();
      en = 1'b0;

      // VPC-4 wraps
      VPC = 32'h0000_0000; BDIn = 1'b1; ExcCodeIn = 5'd1;
      expect_val("wrap_req", SEL_REQ, 32'd1);
      step();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      expect_val("wrap_epc", SEL_EPC, 32'hFFFF_FFFC);
      read_exp("wrap_cause", 5'd13, 32'h8000_0004);

      // Reset mid-exception, overriding a same-edge mtc0
      reset = 1'b1; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0403;
      step();
      reset = 1'b0; en = 1'b0;
      read_exp("rst2_sr", 5'd12, 32'h0000_0000);
      read_exp("rst2_cause", 5'd13, 32'h0000_0000);
      read_exp("rst2_epc", 5'd14, 32'h0000_0000);
      read_exp("rst2_prid", 5'd15, 32'h2024_0001);
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0801;
      step();
      en = 1'b0; HWInt = 6'b000010;
      expect_val("rst2_int_req", SEL_REQ, 32'd1);
      step();
      HWInt = 6'd0;

      // Drain remaining expectations with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step();
      end
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL have a single clock, and reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be as follows (direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  mtc0 write enable.
- CP0Add  in  5  register number for mtc0 write and mfc0 read.
- CP0In  in  32  mtc0 write data.
- VPC  in  32  PC of the instruction being committed.
- BDIn  in  1  committed instruction sits in a branch delay slot.
- ExcCodeIn  in  5  synchronous exception code; 0 = none.
- HWInt  in  6  external hardware interrupt lines.
- EXLClr  in  1  eret commit; clears exception level.
- CP0Out  out  32  mfc0 read data; feeds the write-back select as CP0out.
- EPCOut  out  32  current EPC, for the eret target.
- Req  out  1  exception/interrupt request to flush the pipeline and redirect to 0x0000_4180.

Function
REQ-003 The block SHALL implement four registers:
- SR (12): IM = bits [15:10], EXL = bit 1, IE = bit 0; all other bits read 0.
- Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]; all other bits read 0.
- EPC (14): 32 bits, bits [1:0] always 0.
- PRId (15): constant 32'h2024_0001.
REQ-004 The block SHALL define IntReq as |(HWInt & SR.IM) && SR.IE && !SR.EXL.
REQ-005 The block SHALL define ExcReq as (ExcCodeIn != 0) && !SR.EXL.
REQ-006 Req SHALL be IntReq || ExcReq, combinationally, within the same cycle.
REQ-007 Interrupts SHALL take priority over exceptions: when IntReq is 1, ExcCode SHALL latch 0 regardless of ExcCodeIn; otherwise it SHALL latch ExcCodeIn.
REQ-008 On a clock edge with Req=1, the block SHALL set EXL to 1, latch ExcCode, set BD to BDIn, and set EPC to (BDIn ? VPC-4 : VPC) with bits [1:0] forced to 0.
REQ-009 Cause.IP SHALL load HWInt on every non-reset edge, independent of Req, EXL and en.
REQ-010 EXL SHALL operate as a two-state machine:
- NORMAL (EXL=0) goes to EXC on Req.
- EXC (EXL=1) goes to NORMAL on EXLClr.
- In EXC, Req SHALL be 0 and new requests SHALL be masked, but IP SHALL keep tracking.
REQ-011 Simultaneous Req and EXLClr SHALL give EXL=1; Req wins.
REQ-012 An mtc0 write (en=1) SHALL take effect only when Req=0; on the same edge as Req, the write SHALL be discarded.
REQ-013 mtc0 writes SHALL be accepted only for SR and EPC:
- SR stores CP0In masked to IM/EXL/IE.
- EPC stores CP0In with bits [1:0] forced to 0.
- Writes to Cause, PRId, or any other address SHALL be ignored.
REQ-014 An mtc0 write to SR together with EXLClr on the same edge SHALL give EXL=0; the other SR fields SHALL come from CP0In.
REQ-015 CP0Out SHALL be a combinational read of the register selected by CP0Add, reflecting pre-edge state; unimplemented addresses SHALL read 32'h0.
REQ-016 EPCOut SHALL always equal the EPC register.
REQ-017 VPC-4 SHALL be computed modulo 2^32; VPC=0 with BDIn=1 SHALL yield EPC=32'hFFFF_FFFC.

Reset
REQ-018 On a reset edge, SR, Cause and EPC SHALL clear to 0, so that Req=0, CP0Out=0 for addresses 12, 13 and 14, and EPCOut=0.
REQ-019 Reset SHALL override Req, EXLClr and en on the same edge, and SHALL abort any exception in progress.
REQ-020 PRId SHALL be unaffected by reset.

Verification
REQ-021 Exception entry and return: reset; ExcCodeIn=5'd4, VPC=32'h0000_3008, BDIn=0 -> Req=1 in the same cycle. After the edge: EPC=32'h0000_3008, Cause[6:2]=4, EXL=1, Req=0 while ExcCodeIn is held. Then EXLClr=1 -> EXL=0.
REQ-022 Delay-slot exception: VPC=32'h0000_300C, BDIn=1, ExcCodeIn=5'd10 -> EPC=32'h0000_3008, Cause[31]=1.
REQ-023 Interrupt masking:
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1) then HWInt=6'b000001 -> Req=1, ExcCode=0.
- With SR=32'h0000_0400 (IE=0), the same HWInt -> Req=0, Cause[10]=1.
REQ-024 Interrupt-over-exception priority: HWInt enabled and ExcCodeIn=5'd12 in the same cycle -> ExcCode=0. An mtc0 EPC=32'h1234_5678 issued on that edge -> discarded; EPC=VPC.
REQ-025 Write masking and alignment:
- mtc0 EPC=32'h0000_3003 -> EPCOut=32'h0000_3000.
- mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
- Read of address 15 -> 32'h2024_0001.
- Read of address 3 -> 0.
REQ-026 Reset mid-exception: EXL=1, assert reset -> SR, Cause and EPC read 0 next cycle. Re-enable interrupts, then HWInt raised -> Req=1 again.
